// File: rtl/fp32_decoder_if.sv
// Stream interface for the binary32 field decoder: raw word in, registered decode out.
// The normalize outputs exist only when FP32_DECODER_NORMALIZE_EN is defined.
interface fp32_decoder_if;
  logic        in_valid;
  logic [31:0] data;
  logic        out_valid;
  logic        sign;
  logic [7:0]  exponent;
  logic [22:0] mantissa;
  logic        is_zero, is_denorm, is_norm, is_inf, is_nan;
  logic        is_snan, is_qnan;
  logic [9:0]  exp_unbiased;
  logic [23:0] significand;
`ifdef FP32_DECODER_NORMALIZE_EN
  logic [4:0]  lzc;
  logic [23:0] norm_significand;
  logic [9:0]  norm_exp;

  modport master (output in_valid, data,
                  input  out_valid, sign, exponent, mantissa, is_zero, is_denorm, is_norm,
                         is_inf, is_nan, is_snan, is_qnan, exp_unbiased, significand,
                         lzc, norm_significand, norm_exp);
  modport slave  (input  in_valid, data,
                  output out_valid, sign, exponent, mantissa, is_zero, is_denorm, is_norm,
                         is_inf, is_nan, is_snan, is_qnan, exp_unbiased, significand,
                         lzc, norm_significand, norm_exp);
`else
  modport master (output in_valid, data,
                  input  out_valid, sign, exponent, mantissa, is_zero, is_denorm, is_norm,
                         is_inf, is_nan, is_snan, is_qnan, exp_unbiased, significand);
  modport slave  (input  in_valid, data,
                  output out_valid, sign, exponent, mantissa, is_zero, is_denorm, is_norm,
                         is_inf, is_nan, is_snan, is_qnan, exp_unbiased, significand);
`endif
endinterface

// File: rtl/fp32_decoder.sv
// Registered binary32 field decoder/classifier; one cycle latency, no backpressure.
// Optional FP32_DECODER_NORMALIZE_EN adds leading-zero count and denormal normalization.
module fp32_decoder (
  input  logic           clk,
  input  logic           rst_n,
  fp32_decoder_if.slave  bus
);
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
    logic        is_zero, is_denorm, is_norm, is_inf, is_nan;
    logic        is_snan, is_qnan;
    logic [9:0]  exp_unbiased;
    logic [23:0] significand;
`ifdef FP32_DECODER_NORMALIZE_EN
    logic [4:0]  lzc;
    logic [23:0] norm_significand;
    logic [9:0]  norm_exp;
`endif
  } dec_t;

  dec_t dec, dec_q;
  logic vld_q;
  logic exp_zero, exp_ones, man_zero;

  assign exp_zero = (bus.data[30:23] == 8'h00);
  assign exp_ones = (bus.data[30:23] == 8'hff);
  assign man_zero = (bus.data[22:0] == 23'd0);

  always_comb begin
    dec           = '0;
    dec.sign      = bus.data[31];
    dec.exponent  = bus.data[30:23];
    dec.mantissa  = bus.data[22:0];
    dec.is_zero   = exp_zero & man_zero;
    dec.is_denorm = exp_zero & ~man_zero;
    dec.is_norm   = ~exp_zero & ~exp_ones;
    dec.is_inf    = exp_ones & man_zero;
    dec.is_nan    = exp_ones & ~man_zero;
    dec.is_qnan   = dec.is_nan & bus.data[22];
    dec.is_snan   = dec.is_nan & ~bus.data[22];
    // Zero/denorm share the minimum normal exponent; specials report exp_max+1.
    if (exp_zero)      dec.exp_unbiased = 10'h382;
    else if (exp_ones) dec.exp_unbiased = 10'd128;
    else               dec.exp_unbiased = {2'b00, bus.data[30:23]} - 10'd127;
    dec.significand = {dec.is_norm, bus.data[22:0]};
`ifdef FP32_DECODER_NORMALIZE_EN
    // Highest set bit wins since later iterations overwrite earlier ones.
    if (dec.is_denorm) begin
      for (int i = 0; i < 23; i++)
        if (bus.data[i]) dec.lzc = 5'(23 - i);
    end
    dec.norm_significand = dec.significand << dec.lzc;
    dec.norm_exp         = dec.exp_unbiased - {5'd0, dec.lzc};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) dec_q <= dec;
    end
  end

  assign bus.out_valid    = vld_q;
  assign bus.sign         = dec_q.sign;
  assign bus.exponent     = dec_q.exponent;
  assign bus.mantissa     = dec_q.mantissa;
  assign bus.is_zero      = dec_q.is_zero;
  assign bus.is_denorm    = dec_q.is_denorm;
  assign bus.is_norm      = dec_q.is_norm;
  assign bus.is_inf       = dec_q.is_inf;
  assign bus.is_nan       = dec_q.is_nan;
  assign bus.is_snan      = dec_q.is_snan;
  assign bus.is_qnan      = dec_q.is_qnan;
  assign bus.exp_unbiased = dec_q.exp_unbiased;
  assign bus.significand  = dec_q.significand;
`ifdef FP32_DECODER_NORMALIZE_EN
  assign bus.lzc              = dec_q.lzc;
  assign bus.norm_significand = dec_q.norm_significand;
  assign bus.norm_exp         = dec_q.norm_exp;
`endif
endmodule

// File: tb/tb_fp32_decoder.sv
// Scoreboard bench for fp32_decoder: arithmetic reference model, queued expectations,
// monitor compares on out_valid. Also covers reset, hold and async reset mid-stream.
module tb_fp32_decoder;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
    logic        is_zero, is_denorm, is_norm, is_inf, is_nan;
    logic        is_snan, is_qnan;
    logic [9:0]  exp_unbiased;
    logic [23:0] significand;
`ifdef FP32_DECODER_NORMALIZE_EN
    logic [4:0]  lzc;
    logic [23:0] norm_significand;
    logic [9:0]  norm_exp;
`endif
  } res_t;

  logic clk = 0;
  logic rst_n = 0;
  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];
  res_t last_exp;
  logic mon_en = 1;

  fp32_decoder_if bus();
  fp32_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic res_t model(logic [31:0] d);
    res_t r;
    int e, m, eu, sig;
    r = '0;
    e = int'(d[30:23]);
    m = int'(d[22:0]);
    r.sign      = d[31];
    r.exponent  = d[30:23];
    r.mantissa  = d[22:0];
    r.is_zero   = (e == 0) && (m == 0);
    r.is_denorm = (e == 0) && (m != 0);
    r.is_norm   = (e >= 1) && (e <= 254);
    r.is_inf    = (e == 255) && (m == 0);
    r.is_nan    = (e == 255) && (m != 0);
    r.is_qnan   = r.is_nan && (m >= (1 << 22));
    r.is_snan   = r.is_nan && (m < (1 << 22));
    if (e == 0)        eu = -126;
    else if (e == 255) eu = 128;
    else               eu = e - 127;
    r.exp_unbiased = eu[9:0];
    sig = r.is_norm ? m + (1 << 23) : m;
    r.significand = sig[23:0];
`ifdef FP32_DECODER_NORMALIZE_EN
    begin
      int sh = 0;
      int s  = sig;
      int ne;
      if (r.is_denorm)
        while (s < (1 << 23)) begin s = s * 2; sh++; end
      ne = eu - sh;
      r.lzc = sh[4:0];
      r.norm_significand = s[23:0];
      r.norm_exp = ne[9:0];
    end
`endif
    return r;
  endfunction

  function automatic res_t actual();
    res_t a;
    a = '0;
    a.sign = bus.sign; a.exponent = bus.exponent; a.mantissa = bus.mantissa;
    a.is_zero = bus.is_zero; a.is_denorm = bus.is_denorm; a.is_norm = bus.is_norm;
    a.is_inf = bus.is_inf; a.is_nan = bus.is_nan; a.is_snan = bus.is_snan;
    a.is_qnan = bus.is_qnan; a.exp_unbiased = bus.exp_unbiased; a.significand = bus.significand;
`ifdef FP32_DECODER_NORMALIZE_EN
    a.lzc = bus.lzc; a.norm_significand = bus.norm_significand; a.norm_exp = bus.norm_exp;
`endif
    return a;
  endfunction

  task automatic check_res(string name, res_t act, res_t exp_r);
    checks++;
    if (act !== exp_r) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp_r);
    end
  endtask

  task automatic check_bit(string name, logic act, logic exp_b);
    checks++;
    if (act !== exp_b) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp_b);
    end
  endtask

  // Monitor: every out_valid cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_en && rst_n && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard: out_valid with empty queue, got %h", actual());
      end else begin
        check_res("decode", actual(), exp_q.pop_front());
      end
    end
  end

  task automatic send(logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.data     = d;
    last_exp     = model(d);
    exp_q.push_back(last_exp);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] directed [0:10] = '{32'h00000000, 32'h80000000, 32'h00000001, 32'h80000001,
                                   32'h00800000, 32'h80800000, 32'h3F800000, 32'h7F800000,
                                   32'hFF800000, 32'hFF800001, 32'h7FC00000};

  initial begin
    bus.in_valid = 1'b0;
    bus.data     = 32'h0;
    #1;
    bus.data = 32'hFFFFFFFF;
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_res("reset_outputs", actual(), '0);
    check_bit("reset_out_valid", bus.out_valid, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("idle_out_valid", bus.out_valid, 1'b0);

    // Spot checks of the spec's named cases independent of the model.
    send(32'h00000001);
    idle(1);
    check_bit("denorm_min_flag", bus.is_denorm, 1'b1);
    checks++;
    if (bus.exp_unbiased !== 10'h382 || bus.significand !== 24'h000001) begin
      failures++;
      $display("FAIL denorm_min_fields: got exp %h sig %h expected 382 000001",
               bus.exp_unbiased, bus.significand);
    end
`ifdef FP32_DECODER_NORMALIZE_EN
    checks++;
    if (bus.lzc !== 5'd23 || bus.norm_significand !== 24'h800000 || bus.norm_exp !== 10'h36B) begin
      failures++;
      $display("FAIL denorm_min_norm: got lzc %0d nsig %h nexp %h expected 23 800000 36b",
               bus.lzc, bus.norm_significand, bus.norm_exp);
    end
`endif

    foreach (directed[i]) begin
      send(directed[i]);
      idle(1);
    end

    // Streaming back-to-back, then drop valid and confirm hold.
    send(32'h00000001);
    send(32'h7F800000);
    send(32'h00800000);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_bit("hold_out_valid", bus.out_valid, 1'b0);
    check_res("hold_data", actual(), last_exp);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] w;
      logic [7:0]  e;
      logic [22:0] m;
      w = $urandom();
      case ($urandom_range(0, 3))
        0: e = 8'h00;
        1: e = 8'hFF;
        default: e = w[30:23];
      endcase
      case ($urandom_range(0, 3))
        0: m = 23'd0;
        1: m = 23'd1 << $urandom_range(0, 22);
        default: m = w[22:0];
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send({w[31], e, m});
    end
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    // Async reset between edges must clear outputs with no clock edge.
    send(32'hFF800001);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_res("async_reset_outputs", actual(), '0);
    check_bit("async_reset_out_valid", bus.out_valid, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h7FC00000);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
